// File: rtl/ch8_ram_arbiter.sv
// ch8_ram_arbiter
//   Shares the single-port 4 KiB CHIP-8 byte RAM (synchronous, 1-cycle read
//   latency) between the FDX core (CPU port) and the read-only AUX port that
//   feeds the LED walker / display scanout.
//   - CPU port: byte write, byte read, or 16-bit big-endian word read
//     ({mem[a], mem[a+1]}, with the address wrapping at the top of RAM).
//   - AUX port: byte read.
//   - Arbitration only in IDLE. The CPU normally wins a contested edge, but
//     after MAX_WAIT consecutive contested CPU wins the AUX port is forced
//     ahead, which bounds scanout starvation.
//   All outputs are registered.
//
// Optional feature macro: CH8_RAM_PROTECT_EN
//   When defined, CPU writes below PROT_TOP are granted but never reach the
//   RAM, and prot_err pulses together with cpu_gnt. When undefined, every
//   address is writable and prot_err stays 0.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   cpu_req/we/word/addr/wdata   CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid          one-cycle pulses
//   cpu_rdata[15:0]              {8'h00,byte} or {mem[a],mem[a+1]}
//   prot_err                     one-cycle pulse on a blocked write
//   aux_req/addr                 AUX read request (held until aux_gnt)
//   aux_gnt, aux_rvalid          one-cycle pulses
//   aux_rdata[7:0]               AUX read byte
//   ram_en/we/addr/wdata         RAM command
//   ram_rdata[7:0]               RAM data, valid the cycle after enabled edge

module ch8_ram_arbiter #(
    parameter int                ADDR_W   = 12,
    parameter int                MAX_WAIT = 4,
    parameter logic [ADDR_W-1:0] PROT_TOP = 12'h200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_word,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [15:0]       cpu_rdata,
    output logic              prot_err,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [7:0]        aux_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

`ifdef CH8_RAM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, CPU_WR, CPU_R0, CPU_R1, CPU_R2, AUX_R0, AUX_R1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              word_q, word_d;
    logic [7:0]        hi_q, hi_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [15:0]       cpu_rdata_q, cpu_rdata_d;
    logic              prot_err_q, prot_err_d;
    logic              aux_gnt_q, aux_gnt_d;
    logic              aux_rvalid_q, aux_rvalid_d;
    logic [7:0]        aux_rdata_q, aux_rdata_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;

    logic aux_wins;
    logic wr_blocked;

    // AUX is forced ahead once the CPU has won MAX_WAIT contested edges in a row.
    assign aux_wins   = aux_req && (!cpu_req || (wait_q == 4'(MAX_WAIT)));
    assign wr_blocked = PROT_EN && (cpu_addr < PROT_TOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            word_q       <= 1'b0;
            hi_q         <= '0;
            cpu_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            prot_err_q   <= 1'b0;
            aux_gnt_q    <= 1'b0;
            aux_rvalid_q <= 1'b0;
            aux_rdata_q  <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            word_q       <= word_d;
            hi_q         <= hi_d;
            cpu_gnt_q    <= cpu_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            prot_err_q   <= prot_err_d;
            aux_gnt_q    <= aux_gnt_d;
            aux_rvalid_q <= aux_rvalid_d;
            aux_rdata_q  <= aux_rdata_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        word_d       = word_q;
        hi_d         = hi_q;
        cpu_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        prot_err_d   = 1'b0;
        aux_gnt_d    = 1'b0;
        aux_rvalid_d = 1'b0;
        aux_rdata_d  = aux_rdata_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        case (state_q)
            IDLE: begin
                if (aux_wins) begin
                    aux_gnt_d  = 1'b1;
                    ram_en_d   = 1'b1;
                    ram_addr_d = aux_addr;
                    wait_d     = '0;
                    state_d    = AUX_R0;
                end else if (cpu_req) begin
                    cpu_gnt_d  = 1'b1;
                    ram_addr_d = cpu_addr;
                    // Saturates at MAX_WAIT: a contested edge at MAX_WAIT goes to AUX.
                    if (aux_req && (wait_q != 4'(MAX_WAIT))) begin
                        wait_d = wait_q + 4'd1;
                    end
                    if (cpu_we) begin
                        // A blocked write still walks CPU_WR so timing is unchanged.
                        ram_wdata_d = cpu_wdata;
                        ram_en_d    = !wr_blocked;
                        ram_we_d    = !wr_blocked;
                        prot_err_d  = wr_blocked;
                        state_d     = CPU_WR;
                    end else begin
                        ram_en_d = 1'b1;
                        word_d   = cpu_word;
                        hi_d     = '0;
                        state_d  = cpu_word ? CPU_R0 : CPU_R1;
                    end
                end
            end
            CPU_WR: state_d = IDLE;
            CPU_R0: begin
                // Second byte of a word read; wraps naturally at the top of RAM.
                ram_en_d   = 1'b1;
                ram_addr_d = ram_addr_q + ADDR_W'(1);
                state_d    = CPU_R1;
            end
            CPU_R1: begin
                // For a word read the first byte arrives here; a byte read has
                // nothing valid on ram_rdata yet.
                if (word_q) begin
                    hi_d = ram_rdata;
                end
                state_d = CPU_R2;
            end
            CPU_R2: begin
                cpu_rdata_d  = {hi_q, ram_rdata};
                cpu_rvalid_d = 1'b1;
                state_d      = IDLE;
            end
            AUX_R0: state_d = AUX_R1;
            AUX_R1: begin
                aux_rdata_d  = ram_rdata;
                aux_rvalid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign prot_err   = prot_err_q;
    assign aux_gnt    = aux_gnt_q;
    assign aux_rvalid = aux_rvalid_q;
    assign aux_rdata  = aux_rdata_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule
